// File: rtl/led_rgb_sequencer.sv
// led_rgb_sequencer
// Walks a small writable table of RGB colour entries. Each channel's duty
// ramps linearly toward the active entry's target, at most STEP per tick.
// Once all three channels reach their targets, the entry's hold time elapses
// and the sequence advances to the next entry.
//
// Ports:
//   CLK, nRST          sole clock, asynchronous active-low reset
//   Start / Stop       single-cycle pulses; Stop wins when both are high
//   WrEn, WrAddr       table write strobe and entry address
//   WrColor            {B,G,R} target duties, WrHold hold length in ticks
//   LastIdx            index of the final entry (sampled continuously)
//   RDuty/GDuty/BDuty  registered duties to the PWM compare inputs
//   EntryIdx           active entry
//   Busy               high while fading or holding
//   Done               sequence-complete level
//
// Build option LED_SEQ_LOOP_EN: when defined, the sequence wraps to entry 0
// after the last entry instead of stopping, and Done is tied low.
//
// state | meaning
// IDLE  | stopped, duties 0, waiting for Start
// FADE  | stepping duties toward the active entry's target once per tick
// HOLD  | targets reached, counting hold ticks
// DONE  | sequence finished, duties frozen (not built with LED_SEQ_LOOP_EN)
module led_rgb_sequencer #(
    parameter int DW      = 16,
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TICKDIV = 1000,
    parameter int STEP    = 64
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            Start,
    input  logic            Stop,
    input  logic            WrEn,
    input  logic [AW-1:0]   WrAddr,
    input  logic [3*DW-1:0] WrColor,
    input  logic [15:0]     WrHold,
    input  logic [AW-1:0]   LastIdx,
    output logic [DW-1:0]   RDuty,
    output logic [DW-1:0]   GDuty,
    output logic [DW-1:0]   BDuty,
    output logic [AW-1:0]   EntryIdx,
    output logic            Busy,
    output logic            Done
);

    localparam int            TW        = $clog2(TICKDIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKDIV - 1);
    localparam logic [DW-1:0] STEP_V    = DW'(STEP);

`ifdef LED_SEQ_LOOP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_FADE, ST_HOLD} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_FADE, ST_HOLD, ST_DONE} state_t;
`endif

    // Table storage carries no reset; it is always written before use.
    logic [3*DW-1:0] color_mem [DEPTH];
    logic [15:0]     hold_mem  [DEPTH];

    always_ff @(posedge CLK) begin
        if (WrEn) begin
            color_mem[WrAddr] <= WrColor;
            hold_mem[WrAddr]  <= WrHold;
        end
    end

    state_t        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [15:0]   hold_cnt_q, hold_cnt_d;
    logic [DW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [3*DW-1:0] tgt;
    logic [15:0]     hold_tgt;
    logic            tick;

    // Asynchronous read: a same-cycle write to this entry lands at the edge,
    // so the current cycle still sees the old contents.
    assign tgt      = color_mem[idx_q];
    assign hold_tgt = hold_mem[idx_q];
    assign tick     = (cnt_q == TICK_LAST);

    function automatic logic [DW-1:0] step_toward(input logic [DW-1:0] cur,
                                                  input logic [DW-1:0] goal);
        logic [DW-1:0] diff;
        if (goal > cur) begin
            diff        = goal - cur;
            step_toward = (diff > STEP_V) ? cur + STEP_V : goal;
        end else begin
            diff        = cur - goal;
            step_toward = (diff > STEP_V) ? cur - STEP_V : goal;
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_cnt_d = hold_cnt_q;
        r_d        = r_q;
        g_d        = g_q;
        b_d        = b_q;
        idx_d      = idx_q;
        done_d     = done_q;

        if (Stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            r_d     = '0;
            g_d     = '0;
            b_d     = '0;
            idx_d   = '0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_FADE: begin
                    cnt_d = tick ? '0 : cnt_q + TW'(1);
                    if (tick) begin
                        r_d = step_toward(r_q, tgt[DW-1:0]);
                        g_d = step_toward(g_q, tgt[2*DW-1:DW]);
                        b_d = step_toward(b_q, tgt[3*DW-1:2*DW]);
                        if (r_d == tgt[DW-1:0] && g_d == tgt[2*DW-1:DW] &&
                            b_d == tgt[3*DW-1:2*DW]) begin
                            state_d    = ST_HOLD;
                            hold_cnt_d = '0;
                        end
                    end
                end
                ST_HOLD: begin
                    cnt_d = tick ? '0 : cnt_q + TW'(1);
                    if (tick) begin
                        if (hold_cnt_q != hold_tgt) begin
                            hold_cnt_d = hold_cnt_q + 16'd1;
                        end else if (idx_q < LastIdx) begin
                            idx_d   = idx_q + AW'(1);
                            state_d = ST_FADE;
                        end else begin
`ifdef LED_SEQ_LOOP_EN
                            idx_d   = '0;
                            state_d = ST_FADE;
`else
                            state_d = ST_DONE;
                            cnt_d   = '0;
                            done_d  = 1'b1;
`endif
                        end
                    end
                end
                default: begin
                    // IDLE and DONE: wait for Start; duties keep their values.
                    if (Start) begin
                        state_d = ST_FADE;
                        cnt_d   = '0;
                        idx_d   = '0;
                        done_d  = 1'b0;
                    end
                end
            endcase
        end

        busy_d = (state_d == ST_FADE) || (state_d == ST_HOLD);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hold_cnt_q <= '0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_cnt_q <= hold_cnt_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign RDuty    = r_q;
    assign GDuty    = g_q;
    assign BDuty    = b_q;
    assign EntryIdx = idx_q;
    assign Busy     = busy_q;
`ifdef LED_SEQ_LOOP_EN
    assign Done     = 1'b0;
`else
    assign Done     = done_q;
`endif

endmodule

// File: doc/led_rgb_sequencer.md
# led_rgb_sequencer

Colour-sequence controller for the three-channel RGB PWM LED path. Holds a small writable table of colour entries (R/G/B duty plus hold time) and walks through it, ramping each channel's duty linearly toward the active entry's target, then holding. Its three duty outputs drive the compare inputs of the per-colour PWM instances, which keep a fixed period.

## Interface
- `DW`, 16: duty width per channel; matches PWM compare width.
- `DEPTH`, 8: table entries; power of two, ≥2.
- `AW`, 3: index width, log2(DEPTH).
- `TICKDIV`, 1000: CLK cycles per fade/hold tick, ≥2.
- `STEP`, 64: maximum duty change per tick per channel, ≥1.

Ports:
- `CLK` in 1: sole clock.
- `nRST` in 1: reset, asynchronous and active-low.
- `Start` in 1: single-cycle pulse; begins sequencing at entry 0.
- `Stop` in 1: single-cycle pulse; aborts to idle.
- `WrEn` in 1: table write strobe.
- `WrAddr` in AW: entry written.
- `WrColor` in 3*DW: {B,G,R} target duties.
- `WrHold` in 16: hold length in ticks.
- `LastIdx` in AW: index of final entry in sequence; sampled continuously.
- `RDuty`/`GDuty`/`BDuty` out DW: registered duty to PWM.
- `EntryIdx` out AW: active entry.
- `Busy` out 1: high in FADE or HOLD.
- `Done` out 1: sequence-complete level (see Configuration).

## Operation
- States: IDLE, FADE, HOLD, DONE (DONE exists only without the macro).
- Tick counter runs 0..TICKDIV-1 outside IDLE/DONE; `tick` = counter at TICKDIV-1. Counter cleared when entering FADE from IDLE/DONE.
- IDLE/DONE + `Start` → FADE, EntryIdx=0, Done=0. `Start` in FADE/HOLD is ignored.
- FADE, on tick: each channel moves toward target by min(STEP, |target−duty|); unsigned, no overshoot, no wrap. After the update, if all three equal target → HOLD, hold count=0. If already equal on entry to FADE, transition happens on the first tick.
- HOLD, on tick: if hold count == entry hold → advance; else count+1. Hold 0 leaves on the first tick.
- Advance: EntryIdx<LastIdx → EntryIdx+1, FADE. EntryIdx≥LastIdx → end-of-sequence (Configuration).
- `Stop` in any state → IDLE next cycle, all duties 0, EntryIdx 0, Done 0. `Stop` and `Start` in the same cycle → Stop wins.
- Table writes are accepted in any state and are visible from the next cycle. Rewriting the active entry retargets a fade in progress. A write and a read of the same entry in the same cycle return the old value.
- Table contents are not reset; the bench writes entries before `Start`.

## Timing
- Reset values: duties 0, EntryIdx 0, Busy 0, Done 0, state IDLE, tick counter 0.
- `Start` at cycle n → Busy=1 at n+1; first duty change at n+TICKDIV.
- All outputs registered. Duty changes at most once per TICKDIV cycles.
- State transitions occur in the same cycle as the duty update that completes a fade, so HOLD begins counting on the following tick.
- `nRST` asserted mid-operation clears everything asynchronously. Sequencing resumes only on a new `Start`.

## Configuration
- `LED_SEQ_LOOP_EN` defined: end-of-sequence wraps EntryIdx to 0 and enters FADE. DONE is not implemented and `Done` is tied 0; the sequence runs until `Stop`.
- Not defined: end-of-sequence enters DONE. Busy=0, Done=1, duties hold their last values, and `Start` restarts the sequence.

## Test plan
Bench settings: TICKDIV=4, STEP=64, DW=16.
- Reset: assert nRST low mid-FADE → all outputs 0 immediately; after release, no activity without Start.
- Entry0 {R=256,G=0,B=0}, hold 2, LastIdx=0; Start at cycle 0 → R=64,128,192,256 at cycles 4,8,12,16; HOLD for ticks at 20,24,28; then advance.
- Clamp and descend: entry0 R=100, entry1 R=0, hold 0, LastIdx=1 → R goes 64,100 (HOLD), then 36,0; no undershoot below 0.
- Stop mid-FADE with R=128 → next cycle duties 0, Busy 0. Start and Stop in the same cycle → stays IDLE.
- End of sequence with LastIdx=1: with LED_SEQ_LOOP_EN → EntryIdx returns to 0 and Busy stays 1. Without it → Done=1, Busy=0, duties frozen; a new Start clears Done.
- Retarget: during entry0 fade toward R=256, write entry0 R=64 when R=128 → R steps down to 64, then HOLD.
